cochlea_bank_scheduler: RTL and testbench
=========================================

COCHLEA_BANK_SCHEDULER -- requirements
Module: cochlea_bank_scheduler

Interface
REQ-001 Parameter NUM_BANKS, default 6, number of digital_unison banks sequenced (1..8).
REQ-002 Parameter DIV_W, default 8, width of clock half-period divider.
REQ-003 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a sweep; ignored when busy=1 or bank_en=0.
REQ-006 stop  in  1  one-cycle request to end operation at the next bank boundary.
REQ-007 continuous  in  1  1 = wrap round-robin indefinitely, 0 = single sweep.
REQ-008 bank_en  in  NUM_BANKS  per-bank service mask.
REQ-009 div_cfg  in  DIV_W  clk_master half-period minus 1, in wb_clk_i cycles.
REQ-010 frames_cfg  in  16  clk_master periods per bank visit; 0 treated as 1.
REQ-011 ud_en_cfg  in  1  value driven on ud_en while busy.
REQ-012 read_out_I  in  2*NUM_BANKS  bank b occupies bits [2b+1:2b].
REQ-013 read_out_Q  in  2*NUM_BANKS  same packing as read_out_I.
REQ-014 clk_master  out  NUM_BANKS  per-bank master clock; only active bank toggles.
REQ-015 rstb  out  1  shared bank reset, active-low.
REQ-016 ud_en  out  1  shared up/down enable.
REQ-017 sample_valid / sample_ready  out/in  1/1  capture handshake.
REQ-018 sample_bank  out  3  bank index of captured sample.
REQ-019 sample_data  out  4  {read_out_I[2b+1:2b], read_out_Q[2b+1:2b]}.
REQ-020 busy / done / stall_drop  out  1 each  not-IDLE / end pulse / timeout pulse.

Function
REQ-021 States SHALL be IDLE, ARM, CLOCK, CAPTURE; all outputs registered.
REQ-022 Accepted start SHALL latch bank_en, div_cfg, frames_cfg, continuous, ud_en_cfg into shadow registers; later input changes SHALL NOT affect the running sweep.
REQ-023 IDLE->ARM on accepted start; current bank = lowest enabled index; rstb=1, ud_en=shadow ud_en_cfg from the ARM entry cycle.
REQ-024 ARM SHALL last exactly 4 cycles, then enter CLOCK.
REQ-025 In CLOCK, active bank clk_master SHALL be high div_cfg+1 cycles then low div_cfg+1 cycles per period, starting high on the first CLOCK cycle; all other clk_master bits 0.
REQ-026 After frames_cfg periods (final low phase complete), CLOCK->CAPTURE.
REQ-027 On CAPTURE entry, sample_data/sample_bank SHALL be registered from the active bank and sample_valid=1 the same cycle; held stable while sample_valid=1.
REQ-028 Transfer occurs on sample_valid&&sample_ready; sample_valid SHALL drop the next cycle.
REQ-029 After transfer: stop pending -> IDLE; else next enabled bank above current -> ARM-free direct CLOCK; none above and continuous=1 -> lowest enabled bank, CLOCK; none above and continuous=0 -> IDLE.
REQ-030 stop SHALL be remembered in a pending flag until the next CAPTURE transfer; stop in IDLE SHALL be ignored.
REQ-031 Entering IDLE SHALL drive rstb=0, ud_en=0, clk_master=0, busy=0 and pulse done for exactly one cycle.
REQ-032 start and stop in the same cycle while IDLE: start accepted, stop pending set.
REQ-033 Single enabled bank with continuous=1 SHALL revisit the same bank indefinitely.

Reset
REQ-034 wb_rst_i assertion SHALL immediately force IDLE, all outputs 0 (including rstb=0), clear shadow, pending and counter registers, irrespective of state.
REQ-035 Reset mid-CLOCK or mid-CAPTURE SHALL abort without done pulse; first start after release behaves as from power-up.

Configuration
REQ-036 Macro SCHED_STALL_TIMEOUT_EN: when defined, a CAPTURE with sample_valid=1 for 256 consecutive cycles without ready SHALL drop the sample, pulse stall_drop one cycle and proceed per REQ-029.
REQ-037 Without SCHED_STALL_TIMEOUT_EN, CAPTURE SHALL wait indefinitely and stall_drop SHALL be tied 0.

Verification
REQ-038 bank_en=6'b000101, div_cfg=1, frames_cfg=2, continuous=0, start -> 4 ARM cycles; bank0 clk_master 2 high/2 low x2; sample bank 0; bank2 same; done one cycle; rstb back to 0.
REQ-039 read_out_I[5:4]=2'b10, read_out_Q[5:4]=2'b01, bank 2 captured -> sample_data=4'b1001, sample_bank=2; ready held low 10 cycles -> data stable, clk_master all 0.
REQ-040 continuous=1, bank_en=6'b100000, stop asserted mid-CLOCK -> current visit completes, one sample transferred, then IDLE with done.
REQ-041 frames_cfg=0, div_cfg=0 -> exactly one period, 1 high/1 low, then CAPTURE.
REQ-042 wb_rst_i during CAPTURE with valid=1 -> all outputs 0 same cycle, no done; new start works.
REQ-043 With SCHED_STALL_TIMEOUT_EN, ready held 0 -> stall_drop at cycle 256 of CAPTURE, next bank serviced; without macro -> no drop after 1000 cycles.

Source files
------------

// File: rtl/cochlea_bank_scheduler_if.sv
// Sample capture handshake between the bank scheduler (master) and its consumer (slave).
interface cochlea_bank_scheduler_if;
  logic       sample_valid;
  logic       sample_ready;
  logic [2:0] sample_bank;
  logic [3:0] sample_data;

  modport master (output sample_valid, sample_bank, sample_data, input sample_ready);
  modport slave  (input sample_valid, sample_bank, sample_data, output sample_ready);
endinterface

// File: rtl/cochlea_bank_scheduler.sv
// Sequences enabled digital_unison banks: ARM, clock each bank for a number of frames, capture its I/Q sample.
// Optional SCHED_STALL_TIMEOUT_EN drops a sample after 256 stalled CAPTURE cycles and pulses stall_drop.
module cochlea_bank_scheduler #(
  parameter int NUM_BANKS = 6,
  parameter int DIV_W     = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [NUM_BANKS-1:0]   bank_en,
  input  logic [DIV_W-1:0]       div_cfg,
  input  logic [15:0]            frames_cfg,
  input  logic                   ud_en_cfg,
  input  logic [2*NUM_BANKS-1:0] read_out_I,
  input  logic [2*NUM_BANKS-1:0] read_out_Q,
  output logic [NUM_BANKS-1:0]   clk_master,
  output logic                   rstb,
  output logic                   ud_en,
  output logic                   busy,
  output logic                   done,
  output logic                   stall_drop,
  cochlea_bank_scheduler_if.master smp
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CLOCK, S_CAPTURE} state_t;

  state_t               state_reg;
  logic [2:0]           bank_reg;
  logic [NUM_BANKS-1:0] en_sh_reg;
  logic [DIV_W-1:0]     div_sh_reg;
  logic [15:0]          frames_sh_reg;
  logic                 cont_sh_reg;
  logic                 stop_pend_reg;
  logic [1:0]           arm_cnt_reg;
  logic [DIV_W-1:0]     div_cnt_reg;
  logic [15:0]          frame_cnt_reg;
  logic                 phase_hi_reg;
  logic [NUM_BANKS-1:0] clk_master_reg;
  logic                 rstb_reg;
  logic                 ud_en_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 valid_reg;
  logic [2:0]           sbank_reg;
  logic [3:0]           sdata_reg;

  logic [2:0] first_en;
  logic [2:0] wrap_bank;
  logic [2:0] above_idx;
  logic       above_found;
  logic [2:0] next_bank;
  logic       end_sweep;
  logic       stall_expire;
  logic       advance;
  logic       start_ok;

  // Per-bank {I,Q} slices padded to 8 entries so a 3-bit index is always in range
  logic [3:0] bank_sample [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      if (gi < NUM_BANKS) begin : g_used
        assign bank_sample[gi] = {read_out_I[2*gi+1:2*gi], read_out_Q[2*gi+1:2*gi]};
      end else begin : g_pad
        assign bank_sample[gi] = 4'd0;
      end
    end
  endgenerate

  function automatic logic [2:0] lowest(input logic [NUM_BANKS-1:0] m);
    lowest = 3'd0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  function automatic logic [NUM_BANKS-1:0] onehot(input logic [2:0] b);
    onehot = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (3'(i) == b) onehot[i] = 1'b1;
    end
  endfunction

  always_comb begin
    first_en    = lowest(bank_en);
    wrap_bank   = lowest(en_sh_reg);
    above_found = 1'b0;
    above_idx   = 3'd0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (en_sh_reg[i] && (3'(i) > bank_reg)) begin
        above_found = 1'b1;
        above_idx   = 3'(i);
      end
    end
    next_bank = above_found ? above_idx : wrap_bank;
    // A stop arriving in the very transfer cycle still ends the run here
    end_sweep = stop_pend_reg | stop | (~above_found & ~cont_sh_reg);
  end

  assign start_ok = (state_reg == S_IDLE) && start && (|bank_en);
  assign advance  = (valid_reg && smp.sample_ready) || stall_expire;

`ifdef SCHED_STALL_TIMEOUT_EN
  logic [7:0] stall_cnt_reg;
  logic       stall_drop_reg;

  assign stall_expire = valid_reg && !smp.sample_ready && (stall_cnt_reg == 8'hFF);
  assign stall_drop   = stall_drop_reg;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stall_cnt_reg  <= 8'd0;
      stall_drop_reg <= 1'b0;
    end else begin
      stall_drop_reg <= stall_expire;
      if (state_reg != S_CAPTURE)
        stall_cnt_reg <= 8'd0;
      else if (valid_reg && !advance)
        stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end
  end
`else
  assign stall_expire = 1'b0;
  assign stall_drop   = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg      <= S_IDLE;
      bank_reg       <= 3'd0;
      en_sh_reg      <= '0;
      div_sh_reg     <= '0;
      frames_sh_reg  <= 16'd0;
      cont_sh_reg    <= 1'b0;
      stop_pend_reg  <= 1'b0;
      arm_cnt_reg    <= 2'd0;
      div_cnt_reg    <= '0;
      frame_cnt_reg  <= 16'd0;
      phase_hi_reg   <= 1'b0;
      clk_master_reg <= '0;
      rstb_reg       <= 1'b0;
      ud_en_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      sbank_reg      <= 3'd0;
      sdata_reg      <= 4'd0;
    end else begin
      done_reg <= 1'b0;
      if (stop && state_reg != S_IDLE) stop_pend_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            state_reg     <= S_ARM;
            en_sh_reg     <= bank_en;
            div_sh_reg    <= div_cfg;
            frames_sh_reg <= (frames_cfg == 16'd0) ? 16'd1 : frames_cfg;
            cont_sh_reg   <= continuous;
            ud_en_reg     <= ud_en_cfg;
            stop_pend_reg <= stop;
            bank_reg      <= first_en;
            arm_cnt_reg   <= 2'd0;
            rstb_reg      <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end

        S_ARM: begin
          arm_cnt_reg <= arm_cnt_reg + 2'd1;
          if (arm_cnt_reg == 2'd3) begin
            state_reg      <= S_CLOCK;
            clk_master_reg <= onehot(bank_reg);
            phase_hi_reg   <= 1'b1;
            div_cnt_reg    <= '0;
            frame_cnt_reg  <= 16'd0;
          end
        end

        S_CLOCK: begin
          if (div_cnt_reg == div_sh_reg) begin
            div_cnt_reg <= '0;
            if (phase_hi_reg) begin
              phase_hi_reg   <= 1'b0;
              clk_master_reg <= '0;
            end else if (frame_cnt_reg == frames_sh_reg - 16'd1) begin
              state_reg <= S_CAPTURE;
              valid_reg <= 1'b1;
              sbank_reg <= bank_reg;
              sdata_reg <= bank_sample[bank_reg];
            end else begin
              frame_cnt_reg  <= frame_cnt_reg + 16'd1;
              phase_hi_reg   <= 1'b1;
              clk_master_reg <= onehot(bank_reg);
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        S_CAPTURE: begin
          if (advance) begin
            valid_reg     <= 1'b0;
            stop_pend_reg <= 1'b0;
            if (end_sweep) begin
              state_reg      <= S_IDLE;
              rstb_reg       <= 1'b0;
              ud_en_reg      <= 1'b0;
              clk_master_reg <= '0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
            end else begin
              state_reg      <= S_CLOCK;
              bank_reg       <= next_bank;
              clk_master_reg <= onehot(next_bank);
              phase_hi_reg   <= 1'b1;
              div_cnt_reg    <= '0;
              frame_cnt_reg  <= 16'd0;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign clk_master       = clk_master_reg;
  assign rstb             = rstb_reg;
  assign ud_en            = ud_en_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign smp.sample_valid = valid_reg;
  assign smp.sample_bank  = sbank_reg;
  assign smp.sample_data  = sdata_reg;

endmodule

// File: tb/tb_cochlea_bank_scheduler.sv
// Directed, table-driven bench for cochlea_bank_scheduler plus hand-written multi-cycle sequences.
module tb_cochlea_bank_scheduler;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start, stop, continuous, ud_en_cfg;
  logic [5:0]  bank_en;
  logic [7:0]  div_cfg;
  logic [15:0] frames_cfg;
  logic [11:0] read_out_I, read_out_Q;
  logic [5:0]  clk_master;
  logic        rstb, ud_en, busy, done, stall_drop;

  cochlea_bank_scheduler_if smp ();

  cochlea_bank_scheduler #(.NUM_BANKS(6), .DIV_W(8)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .bank_en    (bank_en),
    .div_cfg    (div_cfg),
    .frames_cfg (frames_cfg),
    .ud_en_cfg  (ud_en_cfg),
    .read_out_I (read_out_I),
    .read_out_Q (read_out_Q),
    .clk_master (clk_master),
    .rstb       (rstb),
    .ud_en      (ud_en),
    .busy       (busy),
    .done       (done),
    .stall_drop (stall_drop),
    .smp        (smp)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [5:0]  en;
    logic [7:0]  div;
    logic [15:0] frames;
    logic [11:0] ri;
    logic [11:0] rq;
    logic        ud;
    int          hold;
    int          exp_n;
    int          exp_first_bank;
    logic [3:0]  exp_first_data;
    int          exp_last_bank;
    logic [3:0]  exp_last_data;
    int          exp_hi;
    int          exp_periods;
  } vec_t;

  vec_t vecs [4];

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    while (!smp.sample_valid && g < 500) begin
      @(negedge wb_clk_i);
      g++;
    end
    chk(name, (g < 500), 1'b1);
  endtask

  task automatic pulse_ready();
    smp.sample_ready = 1'b1;
    @(negedge wb_clk_i);
    smp.sample_ready = 1'b0;
    $display("transfer bank=%0d data=0x%0h", smp.sample_bank, smp.sample_data);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int arm, g, hi, per, tot, stray, bad, nsamp, exp_bank, nb, last_bank;
    logic prev, cur, found;
    logic [11:0] ri, rq;
    logic [3:0] exp_data, d0, last_data;
    ri = v.ri;
    rq = v.rq;
    @(negedge wb_clk_i);
    bank_en = v.en; div_cfg = v.div; frames_cfg = v.frames;
    read_out_I = ri; read_out_Q = rq; ud_en_cfg = v.ud; continuous = 1'b0;
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    // Disturb the config inputs; the running sweep must ignore them
    bank_en = 6'b111111; div_cfg = v.div + 8'd3; frames_cfg = v.frames + 16'd2; ud_en_cfg = ~v.ud;
    chk($sformatf("v%0d_arm_rstb", idx), rstb, 1'b1);
    chk($sformatf("v%0d_arm_ud_en", idx), ud_en, v.ud);
    chk($sformatf("v%0d_arm_busy", idx), busy, 1'b1);
    arm = 0;
    while (busy && clk_master == 6'd0 && !smp.sample_valid && arm < 100) begin
      arm++;
      @(negedge wb_clk_i);
    end
    chk($sformatf("v%0d_arm_cycles", idx), arm, 4);

    exp_bank = 0;
    found = 1'b0;
    for (int b = 0; b < 6; b++) if (!found && v.en[b]) begin exp_bank = b; found = 1'b1; end
    nsamp = 0; last_bank = -1; last_data = 4'd0;
    for (int s = 0; s < 8; s++) begin
      hi = 0; per = 0; tot = 0; stray = 0; prev = 1'b0; g = 0;
      while (!smp.sample_valid && g < 2000) begin
        if ((clk_master & ~(6'b1 << exp_bank)) != 6'd0) stray++;
        cur = clk_master[exp_bank];
        if (cur) hi++;
        if (cur && !prev) per++;
        prev = cur; tot++; g++;
        @(negedge wb_clk_i);
      end
      chk($sformatf("v%0d_b%0d_periods", idx, exp_bank), per, v.exp_periods);
      chk($sformatf("v%0d_b%0d_high", idx, exp_bank), hi, v.exp_periods * v.exp_hi);
      chk($sformatf("v%0d_b%0d_cycles", idx, exp_bank), tot, 2 * v.exp_periods * v.exp_hi);
      chk($sformatf("v%0d_b%0d_stray", idx, exp_bank), stray, 0);
      exp_data = {ri[2*exp_bank +: 2], rq[2*exp_bank +: 2]};
      chk($sformatf("v%0d_b%0d_bank", idx, exp_bank), smp.sample_bank, exp_bank);
      chk($sformatf("v%0d_b%0d_data", idx, exp_bank), smp.sample_data, exp_data);
      if (nsamp == 0) begin
        chk($sformatf("v%0d_first_bank", idx), smp.sample_bank, v.exp_first_bank);
        chk($sformatf("v%0d_first_data", idx), smp.sample_data, v.exp_first_data);
      end
      if (v.hold > 0) begin
        d0 = smp.sample_data; bad = 0;
        for (int k = 0; k < v.hold; k++) begin
          @(negedge wb_clk_i);
          if (smp.sample_data !== d0 || smp.sample_bank !== 3'(exp_bank) ||
              clk_master !== 6'd0 || smp.sample_valid !== 1'b1) bad++;
        end
        chk($sformatf("v%0d_b%0d_hold", idx, exp_bank), bad, 0);
      end
      last_bank = smp.sample_bank; last_data = smp.sample_data;
      pulse_ready();
      nsamp++;
      chk($sformatf("v%0d_b%0d_valid_drop", idx, exp_bank), smp.sample_valid, 1'b0);
      found = 1'b0; nb = 0;
      for (int b = exp_bank + 1; b < 6; b++) if (!found && v.en[b]) begin nb = b; found = 1'b1; end
      if (!found) break;
      exp_bank = nb;
    end
    chk($sformatf("v%0d_nsamples", idx), nsamp, v.exp_n);
    chk($sformatf("v%0d_last_bank", idx), last_bank, v.exp_last_bank);
    chk($sformatf("v%0d_last_data", idx), last_data, v.exp_last_data);
    chk($sformatf("v%0d_done", idx), done, 1'b1);
    chk($sformatf("v%0d_end_busy", idx), busy, 1'b0);
    chk($sformatf("v%0d_end_rstb", idx), rstb, 1'b0);
    chk($sformatf("v%0d_end_ud_en", idx), ud_en, 1'b0);
    chk($sformatf("v%0d_end_clk", idx), clk_master, 6'd0);
    @(negedge wb_clk_i);
    chk($sformatf("v%0d_done_width", idx), done, 1'b0);
  endtask

  initial begin
    int cnt, bad;
    wb_rst_i = 1'b1; start = 0; stop = 0; continuous = 0; ud_en_cfg = 0;
    bank_en = 0; div_cfg = 0; frames_cfg = 0; read_out_I = 0; read_out_Q = 0;
    smp.sample_ready = 1'b0;

    vecs[0] = '{6'b000101, 8'd1, 16'd2, 12'h020, 12'h010, 1'b1, 10, 2, 0, 4'h0, 2, 4'h9, 2, 2};
    vecs[1] = '{6'b000010, 8'd0, 16'd0, 12'h00C, 12'h004, 1'b0, 0, 1, 1, 4'hD, 1, 4'hD, 1, 1};
    vecs[2] = '{6'b111111, 8'd2, 16'd1, 12'hA5A, 12'h3C3, 1'b1, 2, 6, 0, 4'hB, 5, 4'h8, 3, 1};
    vecs[3] = '{6'b110000, 8'd0, 16'd3, 12'h400, 12'hC00, 1'b1, 0, 2, 4, 4'h0, 5, 4'h7, 1, 3};

    repeat (3) @(negedge wb_clk_i);
    chk("rst_outputs", {busy, done, rstb, ud_en, stall_drop, smp.sample_valid, clk_master}, 12'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("post_rst_outputs", {busy, done, rstb, ud_en, smp.sample_valid, clk_master}, 11'd0);

    // Start with an empty mask and a lone stop in IDLE are both ignored
    start = 1'b1; bank_en = 6'd0;
    @(negedge wb_clk_i);
    start = 1'b0; stop = 1'b1;
    @(negedge wb_clk_i);
    stop = 1'b0;
    chk("start_empty_mask", busy, 1'b0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Continuous single bank: revisits, then a mid-CLOCK stop ends after the visit
    bank_en = 6'b100000; div_cfg = 8'd1; frames_cfg = 16'd2; continuous = 1'b1;
    read_out_I = 12'h800; read_out_Q = 12'h400; start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    wait_valid("cont_wait1");
    chk("cont_bank1", smp.sample_bank, 3'd5);
    chk("cont_data1", smp.sample_data, 4'b1001);
    pulse_ready();
    chk("cont_revisit", clk_master, 6'b100000);
    repeat (2) @(negedge wb_clk_i);
    stop = 1'b1;
    @(negedge wb_clk_i);
    stop = 1'b0;
    chk("stop_still_busy", busy, 1'b1);
    wait_valid("cont_wait2");
    chk("cont_bank2", smp.sample_bank, 3'd5);
    pulse_ready();
    chk("stop_done", done, 1'b1);
    chk("stop_busy", busy, 1'b0);

    // start and stop together in IDLE: one visit then done even though continuous
    @(negedge wb_clk_i);
    bank_en = 6'b000001; div_cfg = 8'd0; frames_cfg = 16'd1; continuous = 1'b1;
    start = 1'b1; stop = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0; stop = 1'b0;
    wait_valid("startstop_wait");
    pulse_ready();
    chk("startstop_done", done, 1'b1);
    chk("startstop_busy", busy, 1'b0);

    // Reset while a sample is waiting: immediate clear, no done pulse
    @(negedge wb_clk_i);
    bank_en = 6'b000011; continuous = 1'b0; start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    wait_valid("rst_wait");
    #2 wb_rst_i = 1'b1;
    #1 chk("async_rst_outputs", {busy, done, rstb, ud_en, smp.sample_valid, clk_master}, 11'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge wb_clk_i);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst_no_done", bad, 0);
    run_vec(vecs[1], 1);

    // Sample stall with ready held low
    bank_en = 6'b000011; div_cfg = 8'd0; frames_cfg = 16'd1; continuous = 1'b0;
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    wait_valid("stall_wait");
`ifdef SCHED_STALL_TIMEOUT_EN
    cnt = 0;
    while (smp.sample_valid && cnt < 400) begin
      cnt++;
      @(negedge wb_clk_i);
    end
    chk("stall_cycles", cnt, 256);
    chk("stall_drop_pulse", stall_drop, 1'b1);
    chk("stall_next_bank", clk_master, 6'b000010);
    @(negedge wb_clk_i);
    chk("stall_drop_width", stall_drop, 1'b0);
`else
    bad = 0;
    repeat (1000) begin
      @(negedge wb_clk_i);
      if (stall_drop !== 1'b0 || smp.sample_valid !== 1'b1 || clk_master !== 6'd0) bad++;
    end
    chk("no_stall_drop", bad, 0);
    chk("stall_bank_held", smp.sample_bank, 3'd0);
`endif
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
